// File: rtl/histo_readout_seq.sv
// Readout sequencer for the pixel histogram: on frame end it sweeps every bin,
// streams header, bin counts and a 32-bit sum trailer as bytes, then re-arms accumulation.
module histo_readout_seq #(
   parameter int         BINS     = 1024,
   parameter int         RD_LAT   = 4,
   parameter logic [7:0] HDR_BYTE = 8'hA5,
   localparam int        AW       = $clog2(BINS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic          frame_valid,
   output logic          hist_rw,
   output logic [AW-1:0] hist_bin,
   input  logic [23:0]   hist_data,
   output logic [7:0]    m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          busy,
   output logic          done,
   output logic [7:0]    frame_id,
   output logic [31:0]   hist_sum,
   output logic [7:0]    missed,
   output logic [2:0]    o_dbg_state
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_HDR  = 3'd1;
   localparam logic [2:0] S_ADDR = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_EMIT = 3'd4;
   localparam logic [2:0] S_TRL  = 3'd5;

   localparam logic [AW-1:0] LAST_BIN = AW'(BINS - 1);
   localparam logic [3:0]    LAT_INIT = 4'(RD_LAT - 1);

   logic [2:0]    r_state;
   logic          r_fv_d;
   logic [3:0]    r_lat;
   logic [1:0]    r_cnt;
   logic [23:0]   r_shift;
   logic [31:0]   r_run_sum;
   logic [AW-1:0] r_hist_bin;
   logic [7:0]    r_m_data;
   logic          r_m_valid;
   logic          r_done;
   logic [7:0]    r_frame_id;
   logic [31:0]   r_hist_sum;
   logic [7:0]    r_missed;

   logic w_fall;
   logic w_xfer;

   // A byte moves on any cycle with m_valid & m_ready; m_data/m_valid only change after such a cycle.
   assign w_fall = r_fv_d & ~frame_valid;
   assign w_xfer = r_m_valid & m_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_fv_d     <= 1'b0;
         r_lat      <= 4'd0;
         r_cnt      <= 2'd0;
         r_shift    <= 24'd0;
         r_run_sum  <= 32'd0;
         r_hist_bin <= LAST_BIN;
         r_m_data   <= 8'd0;
         r_m_valid  <= 1'b0;
         r_done     <= 1'b0;
         r_frame_id <= 8'd0;
         r_hist_sum <= 32'd0;
         r_missed   <= 8'd0;
      end else begin
         r_fv_d <= frame_valid;
         r_done <= 1'b0;
         if (w_fall && (r_state != S_IDLE) && (r_missed != 8'hFF))
            r_missed <= r_missed + 8'd1;

         case (r_state)
            S_IDLE: begin
               if (w_fall && enable) begin
                  r_state   <= S_HDR;
                  r_m_valid <= 1'b1;
                  r_m_data  <= HDR_BYTE;
                  r_cnt     <= 2'd0;
               end
            end
            S_HDR: begin
               if (w_xfer) begin
                  if (r_cnt == 2'd0) begin
                     r_m_data <= r_frame_id;
                     r_cnt    <= 2'd1;
                  end else begin
                     // Address is presented on entry to ADDR so that cycle counts toward settling.
                     r_m_valid  <= 1'b0;
                     r_hist_bin <= '0;
                     r_state    <= S_ADDR;
                  end
               end
            end
            S_ADDR: begin
               r_lat   <= LAT_INIT;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (r_lat == 4'd0) begin
                  r_shift   <= hist_data;
                  r_run_sum <= r_run_sum + {8'd0, hist_data};
                  r_m_valid <= 1'b1;
                  r_m_data  <= hist_data[23:16];
                  r_cnt     <= 2'd0;
                  r_state   <= S_EMIT;
               end else begin
                  r_lat <= r_lat - 4'd1;
               end
            end
            S_EMIT: begin
               if (w_xfer) begin
                  r_cnt <= r_cnt + 2'd1;
                  case (r_cnt)
                     2'd0:    r_m_data <= r_shift[15:8];
                     2'd1:    r_m_data <= r_shift[7:0];
                     default: begin
                        r_cnt <= 2'd0;
                        if (r_hist_bin == LAST_BIN) begin
                           r_m_data <= r_run_sum[31:24];
                           r_state  <= S_TRL;
                        end else begin
                           r_m_valid  <= 1'b0;
                           r_hist_bin <= r_hist_bin + 1'b1;
                           r_state    <= S_ADDR;
                        end
                     end
                  endcase
               end
            end
            S_TRL: begin
               if (w_xfer) begin
                  r_cnt <= r_cnt + 2'd1;
                  case (r_cnt)
                     2'd0:    r_m_data <= r_run_sum[23:16];
                     2'd1:    r_m_data <= r_run_sum[15:8];
                     2'd2:    r_m_data <= r_run_sum[7:0];
                     default: begin
                        r_m_valid  <= 1'b0;
                        r_hist_sum <= r_run_sum;
                        r_frame_id <= r_frame_id + 8'd1;
                        r_done     <= 1'b1;
                        r_run_sum  <= 32'd0;
                        r_hist_bin <= LAST_BIN;
                        r_cnt      <= 2'd0;
                        r_state    <= S_IDLE;
                     end
                  endcase
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign hist_rw     = (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign hist_bin    = r_hist_bin;
   assign m_data      = r_m_data;
   assign m_valid     = r_m_valid;
   assign done        = r_done;
   assign frame_id    = r_frame_id;
   assign hist_sum    = r_hist_sum;
   assign missed      = r_missed;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_histo_readout_seq.sv
// Directed bench for histo_readout_seq: byte-stream scoreboard against a histogram model,
// plus a second instance with RD_LAT=1 fed by a model that corrupts data on address change.
module tb_histo_readout_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        enable = 1'b1;
   logic        frame_valid = 1'b0;
   logic        hist_rw;
   logic [9:0]  hist_bin;
   logic [23:0] hist_data;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic        busy;
   logic        done;
   logic [7:0]  frame_id;
   logic [31:0] hist_sum;
   logic [7:0]  missed;
   logic [2:0]  dbg_state;

   logic        en2 = 1'b0;
   logic        fv2 = 1'b0;
   logic        hist_rw2;
   logic [9:0]  hist_bin2;
   logic [23:0] hist_data2;
   logic [7:0]  m_data2;
   logic        m_valid2;
   logic        m_ready2 = 1'b1;
   logic        busy2;
   logic        done2;
   logic [7:0]  frame_id2;
   logic [31:0] hist_sum2;
   logic [7:0]  missed2;
   logic [2:0]  dbg_state2;
   logic [9:0]  last_bin2 = 10'd1023;

   logic        data_mode  = 1'b0;
   logic        ready_mode = 1'b0;

   logic [7:0]  exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          done_cnt = 0;
   int          done2_cnt = 0;
   int          pkt_bytes = 0;
   logic        stall_pend = 1'b0;
   logic [7:0]  stall_data = 8'd0;

   always #5 clk = ~clk;

   histo_readout_seq u_dut (
      .clk(clk), .rst(rst), .enable(enable), .frame_valid(frame_valid),
      .hist_rw(hist_rw), .hist_bin(hist_bin), .hist_data(hist_data),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .busy(busy), .done(done), .frame_id(frame_id), .hist_sum(hist_sum),
      .missed(missed), .o_dbg_state(dbg_state)
   );

   histo_readout_seq #(.RD_LAT(1)) u_dut_lat1 (
      .clk(clk), .rst(rst), .enable(en2), .frame_valid(fv2),
      .hist_rw(hist_rw2), .hist_bin(hist_bin2), .hist_data(hist_data2),
      .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready2),
      .busy(busy2), .done(done2), .frame_id(frame_id2), .hist_sum(hist_sum2),
      .missed(missed2), .o_dbg_state(dbg_state2)
   );

   // Histogram models: count = bin + 1 (or all ones); the second one shows garbage on the
   // cycle its address changes and the real count from the next cycle on.
   always_comb hist_data = data_mode ? 24'hFFFFFF : ({14'd0, hist_bin} + 24'd1);
   always @(posedge clk) last_bin2 <= hist_bin2;
   always_comb hist_data2 = (hist_bin2 != last_bin2) ? 24'hDEADBE : ({14'd0, hist_bin2} + 24'd1);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Sink pacing: always ready, or ready on roughly one cycle in three.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         m_ready = (ready_mode == 1'b0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      end
   end

   // Stream monitor / scoreboard, sampled mid-cycle ahead of the edge that transfers.
   always @(negedge clk) begin
      if (rst) begin
         stall_pend = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (done2) done2_cnt++;
         if (stall_pend) begin
            check("stall_valid", {31'd0, m_valid}, 32'd1);
            check("stall_data", {24'd0, m_data}, {24'd0, stall_data});
         end
         if (m_valid && m_ready) begin
            pkt_bytes++;
            check("q_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check("byte", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
         end
         stall_pend = m_valid && !m_ready;
         stall_data = m_data;
      end
   end

   task automatic push_packet(input logic [7:0] fid, input logic all_ones);
      logic [31:0] sum;
      logic [23:0] v;
      sum = 32'd0;
      exp_q.push_back(8'hA5);
      exp_q.push_back(fid);
      for (int b = 0; b < 1024; b++) begin
         v = all_ones ? 24'hFFFFFF : 24'(b + 1);
         exp_q.push_back(v[23:16]);
         exp_q.push_back(v[15:8]);
         exp_q.push_back(v[7:0]);
         sum = sum + {8'd0, v};
      end
      exp_q.push_back(sum[31:24]);
      exp_q.push_back(sum[23:16]);
      exp_q.push_back(sum[15:8]);
      exp_q.push_back(sum[7:0]);
   endtask

   task automatic frame_end();
      frame_valid = 1'b1;
      @(posedge clk); #1;
      frame_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int start;
      int i;
      start = done_cnt;
      i = 0;
      while (done_cnt == start && i < budget) begin
         @(posedge clk); #1;
         i++;
      end
      check(tag, done_cnt - start, 32'd1);
   endtask

   task automatic wait_bin(input string tag, input logic [9:0] target, input int budget);
      int i;
      i = 0;
      while (hist_bin != target && i < budget) begin
         @(posedge clk); #1;
         i++;
      end
      check(tag, {22'd0, hist_bin}, {22'd0, target});
   endtask

   initial begin
      int i;
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_hist_rw", {31'd0, hist_rw}, 32'd1);
      check("rst_hist_bin", {22'd0, hist_bin}, 32'd1023);
      check("rst_m_valid", {31'd0, m_valid}, 32'd0);
      check("rst_m_data", {24'd0, m_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_frame_id", {24'd0, frame_id}, 32'd0);
      check("rst_hist_sum", hist_sum, 32'd0);
      check("rst_missed", {24'd0, missed}, 32'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // 1: count = bin+1, sink always ready
      push_packet(8'd0, 1'b0);
      pkt_bytes = 0;
      frame_valid = 1'b1;
      @(posedge clk); #1;
      frame_valid = 1'b0;
      check("pre_trig_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      check("trig_busy", {31'd0, busy}, 32'd1);
      check("trig_hist_rw", {31'd0, hist_rw}, 32'd0);
      check("trig_hdr", {24'd0, m_data}, 32'h0000_00A5);
      wait_done("t1_done", 9000);
      check("t1_len", pkt_bytes, 32'd3078);
      check("t1_frame_id", {24'd0, frame_id}, 32'd1);
      check("t1_hist_sum", hist_sum, 32'd524800);
      check("t1_hist_rw", {31'd0, hist_rw}, 32'd1);
      check("t1_hist_bin", {22'd0, hist_bin}, 32'd1023);
      check("t1_missed", {24'd0, missed}, 32'd0);
      check("t1_drained", exp_q.size(), 32'd0);
      repeat (5) @(posedge clk);
      #1;
      check("t1_done_once", done_cnt, 32'd1);

      // 2: same data, sink stalls randomly
      ready_mode = 1'b1;
      push_packet(8'd1, 1'b0);
      pkt_bytes = 0;
      frame_end();
      wait_done("t2_done", 30000);
      ready_mode = 1'b0;
      check("t2_len", pkt_bytes, 32'd3078);
      check("t2_frame_id", {24'd0, frame_id}, 32'd2);
      check("t2_hist_sum", hist_sum, 32'd524800);
      check("t2_drained", exp_q.size(), 32'd0);
      repeat (3) @(posedge clk);
      #1;

      // 3: extra frame ends during a sweep only bump missed, saturating at 255
      push_packet(8'd2, 1'b0);
      pkt_bytes = 0;
      frame_end();
      wait_bin("t3_reach_100", 10'd100, 9000);
      frame_end();
      check("t3_missed_1", {24'd0, missed}, 32'd1);
      for (int k = 0; k < 300; k++) frame_end();
      check("t3_missed_sat", {24'd0, missed}, 32'd255);
      check("t3_still_busy", {31'd0, busy}, 32'd1);
      wait_done("t3_done", 9000);
      check("t3_len", pkt_bytes, 32'd3078);
      check("t3_frame_id", {24'd0, frame_id}, 32'd3);
      check("t3_drained", exp_q.size(), 32'd0);
      repeat (3) @(posedge clk);
      #1;

      // 4: all bins full scale, sum wraps
      data_mode = 1'b1;
      push_packet(8'd3, 1'b1);
      frame_end();
      wait_done("t4_done", 9000);
      data_mode = 1'b0;
      check("t4_hist_sum", hist_sum, 32'hFFFF_FC00);
      check("t4_frame_id", {24'd0, frame_id}, 32'd4);
      check("t4_drained", exp_q.size(), 32'd0);
      repeat (3) @(posedge clk);
      #1;

      // 5: reset in mid-sweep, then a clean restart
      push_packet(8'd4, 1'b0);
      frame_end();
      wait_bin("t5_reach_512", 10'd512, 9000);
      i = done_cnt;
      rst = 1'b1;
      @(posedge clk); #1;
      check("t5_hist_rw", {31'd0, hist_rw}, 32'd1);
      check("t5_m_valid", {31'd0, m_valid}, 32'd0);
      check("t5_hist_bin", {22'd0, hist_bin}, 32'd1023);
      check("t5_busy", {31'd0, busy}, 32'd0);
      check("t5_frame_id", {24'd0, frame_id}, 32'd0);
      check("t5_hist_sum", hist_sum, 32'd0);
      check("t5_missed", {24'd0, missed}, 32'd0);
      rst = 1'b0;
      exp_q.delete();
      repeat (5) @(posedge clk);
      #1;
      check("t5_no_done", done_cnt, i);
      push_packet(8'd0, 1'b0);
      pkt_bytes = 0;
      frame_end();
      wait_done("t5_done", 9000);
      check("t5_len", pkt_bytes, 32'd3078);
      check("t5_restart_sum", hist_sum, 32'd524800);
      check("t5_restart_fid", {24'd0, frame_id}, 32'd1);
      check("t5_drained", exp_q.size(), 32'd0);
      repeat (3) @(posedge clk);
      #1;

      // 6: enable low at frame end
      enable = 1'b0;
      i = done_cnt;
      frame_end();
      repeat (20) @(posedge clk);
      #1;
      check("t6_hist_rw", {31'd0, hist_rw}, 32'd1);
      check("t6_busy", {31'd0, busy}, 32'd0);
      check("t6_missed", {24'd0, missed}, 32'd0);
      check("t6_no_done", done_cnt, i);
      enable = 1'b1;

      // 7: RD_LAT=1 instance must sample one cycle after the address change
      en2 = 1'b1;
      fv2 = 1'b1;
      @(posedge clk); #1;
      fv2 = 1'b0;
      i = 0;
      while (done2_cnt == 0 && i < 8000) begin
         @(posedge clk); #1;
         i++;
      end
      check("t7_done", done2_cnt, 32'd1);
      check("t7_hist_sum", hist_sum2, 32'd524800);
      check("t7_frame_id", {24'd0, frame_id2}, 32'd1);
      check("t7_hist_rw", {31'd0, hist_rw2}, 32'd1);
      check("t7_missed", {24'd0, missed2}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
